// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / restoring divide unit feeding HI/LO.
// Optional MD_UNSIGNED_EN adds is_unsigned for MULTU/DIVU with unchanged latency.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div_mult,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MD_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero,
    output logic [1:0]       state_dbg
);
    // Handshake: start is taken only in IDLE with done low; busy stays high until
    // the cycle done pulses, and hi_out/lo_out change only on that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FINISH = 2'd3} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q, mcand_q, corr_q;
    logic             q1_q, op_div_q, zero_q, neg_q_q, neg_r_q;

    logic             uns, accept, b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, corr_d;
    logic [WIDTH:0]   mcand_ext, booth_sum, shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] rem_res, quo_res, mul_hi;

`ifdef MD_UNSIGNED_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif

    assign accept    = (state_q == IDLE) && start && !done;
    assign b_zero    = (b == '0);
    assign a_neg     = !uns && a[WIDTH-1];
    assign b_neg     = !uns && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    // Booth always runs signed; unsigned products get these raw-operand terms added to HI.
    assign corr_d    = uns ? ((a[WIDTH-1] ? b : '0) + (b[WIDTH-1] ? a : '0)) : '0;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    always_comb begin
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        booth_sum = hi_q;
        case ({lo_q[0], q1_q})
            2'b01:   booth_sum = hi_q + mcand_ext;
            2'b10:   booth_sum = hi_q - mcand_ext;
            default: booth_sum = hi_q;
        endcase
        shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, mcand_q};
        rem_res = neg_r_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
        quo_res = neg_q_q ? -lo_q : lo_q;
        mul_hi  = hi_q[WIDTH-1:0] + corr_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (div_mult && b_zero) state_d = FINISH;
                    else if (div_mult)      state_d = DIV;
                    else                    state_d = MULT;
                end
            end
            MULT, DIV: begin
                if (cnt_q == CW'(1)) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            q1_q     <= 1'b0;
            mcand_q  <= '0;
            corr_q   <= '0;
            op_div_q <= 1'b0;
            zero_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_div_q <= div_mult;
                        zero_q   <= div_mult && b_zero;
                        cnt_q    <= CW'(WIDTH);
                        q1_q     <= 1'b0;
                        hi_q     <= '0;
                        corr_q   <= corr_d;
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        // Divide keeps the dividend magnitude in lo_q and the divisor in mcand_q.
                        if (div_mult) begin
                            lo_q    <= a_mag;
                            mcand_q <= b_mag;
                        end else begin
                            lo_q    <= b;
                            mcand_q <= a;
                        end
                    end
                end
                MULT: begin
                    hi_q  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    lo_q  <= {booth_sum[0], lo_q[WIDTH-1:1]};
                    q1_q  <= lo_q[0];
                    cnt_q <= cnt_q - CW'(1);
                end
                DIV: begin
                    if (diff[WIDTH+1]) begin
                        hi_q <= shifted;
                        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        hi_q <= diff[WIDTH:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_q <= cnt_q - CW'(1);
                end
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= zero_q;
                    if (!zero_q) begin
                        hi_out <= op_div_q ? rem_res : mul_hi;
                        lo_out <= op_div_q ? quo_res : lo_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized scoreboard bench for mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         div_mult = 1'b0;
  logic         is_unsigned = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad = 0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] model_hi = '0, model_lo = '0;
  logic [W-1:0] mon_hi = '0, mon_lo = '0;
  logic         prev_done = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .div_mult(div_mult),
    .a(a),
    .b(b),
`ifdef MD_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy(busy),
    .done(done),
    .hi_out(hi_out),
    .lo_out(lo_out),
    .div_zero(div_zero),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: {div_zero, hi, lo}
  function automatic logic [2*W:0] model(input bit div, input bit uns,
                                         input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    logic [63:0] up;
    longint      sp, la, lb, q, r;
    logic [W-1:0] uq, ur;
    if (!div) begin
      if (uns) begin
        up = 64'(op_a) * 64'(op_b);
        return {1'b0, up};
      end
      sp = longint'($signed(op_a)) * longint'($signed(op_b));
      return {1'b0, sp[63:0]};
    end
    if (op_b == '0) return {1'b1, model_hi, model_lo};
    if (uns) begin
      uq = op_a / op_b;
      ur = op_a % op_b;
      return {1'b0, ur, uq};
    end
    la = longint'($signed(op_a));
    lb = longint'($signed(op_b));
    q  = la / lb;
    r  = la % lb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  task automatic push_exp(input bit div, input bit uns, input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    logic [2*W:0] e;
    e = model(div, uns, op_a, op_b);
    exp_q.push_back(e);
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
  endtask

  // driver: issue one op, scramble inputs while busy, bound the wait for done
  task automatic run_op(input bit div, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input bit uns, input bit disturb);
    int cyc;
    bit seen;
    int exp_lat;
`ifndef MD_UNSIGNED_EN
    uns = 1'b0;
`endif
    if (done) begin
      @(posedge clk);
      #1;
    end
    div_mult = div; a = op_a; b = op_b; is_unsigned = uns; start = 1'b1;
    push_exp(div, uns, op_a, op_b);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {64'b0, busy}, 65'd1);
    exp_lat = (div && op_b == '0) ? 1 : LAT;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      a = $urandom; b = $urandom;
      div_mult = 1'($urandom_range(0, 1));
      is_unsigned = 1'($urandom_range(0, 1));
      if (disturb && cyc == 4) start = 1'b1;
      if (disturb && cyc == 6) start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done after %0d cycles, required %0d", cyc, exp_lat);
    end else begin
      check("latency", 65'(cyc), 65'(exp_lat));
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (prev_done) check("done_width", {64'b0, done}, 65'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 hi=%h lo=%h, required no done", hi_out, lo_out);
        end else begin
          logic [2*W:0] e;
          e = exp_q.pop_front();
          check("result", {div_zero, hi_out, lo_out}, e);
          mon_hi = e[2*W-1:W];
          mon_lo = e[W-1:0];
        end
      end else begin
        check("hold", {div_zero, hi_out, lo_out}, {1'b0, mon_hi, mon_lo});
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    #1;
    check("reset_flags", {61'b0, busy, done, div_zero, 1'b0}, 65'd0);
    check("reset_hilo", {1'b0, hi_out, lo_out}, 65'd0);
    check("reset_state", {63'b0, state_dbg}, 65'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b0, 32'd7, -32'sd3, 1'b0, 1'b0);
    run_op(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_op(1'b1, -32'sd7, 32'd2, 1'b0, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);

    // start held during the done cycle must be ignored
    div_mult = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    @(posedge clk);
    #1;
    check("start_on_done_ignored", {64'b0, busy}, 65'd0);
    run_op(1'b0, 32'd11, 32'd13, 1'b0, 1'b0);
    run_op(1'b1, 32'd100, 32'd0, 1'b0, 1'b0);

`ifdef MD_UNSIGNED_EN
    run_op(1'b0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    run_op(1'b1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
`endif

    // asynchronous abort in the middle of a multiply
    run_op(1'b0, 32'd7, -32'sd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    div_mult = 1'b0; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    mon_hi = '0; mon_lo = '0; model_hi = '0; model_lo = '0;
    #1;
    check("abort_busy", {64'b0, busy}, 65'd0);
    check("abort_outputs", {done, div_zero, hi_out, lo_out}, 65'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done_busy", {64'b0, busy}, 65'd0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : W'($urandom);
      case (sel)
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'd1;
        3:       rb = 32'h80000000;
        default: rb = W'($urandom);
      endcase
      run_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), (i % 5) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
